// File: rtl/harness_pkg.sv
// Shared definitions for the processor-harness run sequencer.
package harness_pkg;

  localparam int unsigned MEM_ADDR_W = 8;
  localparam int unsigned MEM_DATA_W = 8;
  localparam int unsigned CYC_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    READ,
    FINISH
  } seq_state_t;

endpackage

// File: rtl/seq_counter.sv
// Loadable, saturating up-counter with a terminal-count compare flag.
module seq_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] count_o,
  output logic         tc_o
);

  logic [W-1:0] count_q;

  // Load has priority over increment; increment stops at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == term_i);

endmodule

// File: rtl/run_sequencer.sv
// Host-side run sequencer: loads an image into data memory, holds the
// processor in start, times the run until done, then streams a result
// window back out of data memory.
module run_sequencer
  import harness_pkg::*;
#(
  parameter int unsigned ADDR_W    = MEM_ADDR_W,
  parameter int unsigned LOAD_BASE = 0,
  parameter int unsigned LOAD_LEN  = 64,
  parameter int unsigned RD_BASE   = 64,
  parameter int unsigned RD_LEN    = 16,
  parameter int unsigned START_CYC = 2,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic                  ld_valid,
  input  logic [MEM_DATA_W-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  dut_start,
  input  logic                  dut_done,
  output logic                  mem_wen,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [MEM_DATA_W-1:0] mem_din,
  input  logic [MEM_DATA_W-1:0] mem_dout,
  output logic                  rb_valid,
  output logic [MEM_DATA_W-1:0] rb_data,
  input  logic                  rb_ready,
  output logic                  busy,
  output logic                  finished,
  output logic                  timeout_err,
  output logic [CYC_W-1:0]      cycle_count
);

  localparam logic [CYC_W-1:0] LOAD_TERM  = CYC_W'((LOAD_LEN  > 0) ? LOAD_LEN  - 1 : 0);
  localparam logic [CYC_W-1:0] START_TERM = CYC_W'((START_CYC > 0) ? START_CYC - 1 : 0);
  localparam logic [CYC_W-1:0] RD_TERM    = CYC_W'((RD_LEN    > 0) ? RD_LEN    - 1 : 0);
  localparam logic [CYC_W-1:0] RUN_TERM   = CYC_W'((TIMEOUT   > 0) ? TIMEOUT   - 1 : 0);

  seq_state_t state_q;
  logic       ld_ready_q, dut_start_q, rb_valid_q, busy_q, finished_q, timeout_q;

  logic             ld_xfer, rb_xfer, go_acc;
  logic             idx_load, idx_inc, idx_tc;
  logic [CYC_W-1:0] idx_term, idx_count;
  logic             run_tc;
  logic [CYC_W-1:0] run_count;

  assign ld_xfer = (state_q == LOAD) && ld_valid;
  assign rb_xfer = (state_q == READ) && rb_ready;
  assign go_acc  = (state_q == IDLE) && go;

  // One index counter serves the load offset, the start hold and the readback
  // offset; it is parked at zero whenever the state does not use it.
  always_comb begin
    idx_load = 1'b1;
    idx_inc  = 1'b0;
    idx_term = LOAD_TERM;
    case (state_q)
      LOAD: begin
        idx_load = ld_xfer && idx_tc;
        idx_inc  = ld_xfer;
      end
      START: begin
        idx_term = START_TERM;
        idx_load = idx_tc;
        idx_inc  = 1'b1;
      end
      READ: begin
        idx_term = RD_TERM;
        idx_load = 1'b0;
        idx_inc  = rb_xfer;
      end
      default: ;
    endcase
  end

  seq_counter #(.W(CYC_W)) u_idx (
    .clk        (clk),
    .reset      (reset),
    .load_i     (idx_load),
    .load_val_i ('0),
    .inc_i      (idx_inc),
    .term_i     (idx_term),
    .count_o    (idx_count),
    .tc_o       (idx_tc)
  );

  // The run counter doubles as the reported cycle count and the timeout timer.
  seq_counter #(.W(CYC_W)) u_run (
    .clk        (clk),
    .reset      (reset),
    .load_i     (go_acc),
    .load_val_i ('0),
    .inc_i      (state_q == RUN),
    .term_i     (RUN_TERM),
    .count_o    (run_count),
    .tc_o       (run_tc)
  );

  // Sequencer FSM with registered status/handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ld_ready_q  <= 1'b0;
      dut_start_q <= 1'b1;
      rb_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (go) begin
            busy_q    <= 1'b1;
            timeout_q <= 1'b0;
            if (LOAD_LEN != 0) begin
              state_q    <= LOAD;
              ld_ready_q <= 1'b1;
            end else begin
              state_q <= START;
            end
          end
        end
        LOAD: begin
          if (ld_xfer && idx_tc) begin
            state_q    <= START;
            ld_ready_q <= 1'b0;
          end
        end
        START: begin
          if (idx_tc) begin
            state_q     <= RUN;
            dut_start_q <= 1'b0;
          end
        end
        RUN: begin
          if (dut_done) begin
            dut_start_q <= 1'b1;
            if (RD_LEN != 0) begin
              state_q    <= READ;
              rb_valid_q <= 1'b1;
            end else begin
              state_q    <= FINISH;
              finished_q <= 1'b1;
            end
          end else if (run_tc) begin
            dut_start_q <= 1'b1;
            timeout_q   <= 1'b1;
            state_q     <= FINISH;
            finished_q  <= 1'b1;
          end
        end
        READ: begin
          if (rb_xfer && idx_tc) begin
            rb_valid_q <= 1'b0;
            state_q    <= FINISH;
            finished_q <= 1'b1;
          end
        end
        FINISH: begin
          finished_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory port is combinational so each load transfer writes on its own edge;
  // the write is masked on a reset cycle so an abort never lands a byte.
  always_comb begin
    mem_wen  = ld_xfer && !reset;
    mem_addr = '0;
    mem_din  = '0;
    rb_data  = '0;
    case (state_q)
      LOAD: begin
        mem_addr = ADDR_W'(LOAD_BASE) + ADDR_W'(idx_count);
        mem_din  = ld_data;
      end
      READ: begin
        mem_addr = ADDR_W'(RD_BASE) + ADDR_W'(idx_count);
        rb_data  = mem_dout;
      end
      default: ;
    endcase
  end

  assign ld_ready    = ld_ready_q;
  assign dut_start   = dut_start_q;
  assign rb_valid    = rb_valid_q;
  assign busy        = busy_q;
  assign finished    = finished_q;
  assign timeout_err = timeout_q;
  assign cycle_count = run_count;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed self-checking bench for run_sequencer.
module tb_run_sequencer;

  logic        clk = 1'b0;
  logic        reset, go, ld_valid, dut_done, rb_ready;
  logic [7:0]  ld_data;

  logic        ld_ready, dut_start, mem_wen, rb_valid, busy, finished, timeout_err;
  logic [7:0]  mem_addr, mem_din, mem_dout, rb_data;
  logic [15:0] cycle_count;

  logic        ld_ready_b, dut_start_b, mem_wen_b, rb_valid_b, busy_b, finished_b, timeout_err_b;
  logic [7:0]  mem_addr_b, mem_din_b, rb_data_b;
  logic [7:0]  mem_dout_b = 8'h00;
  logic [15:0] cycle_count_b;

  logic [7:0]  mem [0:255];

  int checks = 0;
  int errors = 0;
  int fin_cnt = 0;

  always #5 clk = ~clk;

  run_sequencer #(
    .ADDR_W(8), .LOAD_BASE(0), .LOAD_LEN(4), .RD_BASE(64), .RD_LEN(16),
    .START_CYC(2), .TIMEOUT(20)
  ) dut (
    .clk(clk), .reset(reset), .go(go),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .dut_start(dut_start), .dut_done(dut_done),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .rb_valid(rb_valid), .rb_data(rb_data), .rb_ready(rb_ready),
    .busy(busy), .finished(finished), .timeout_err(timeout_err),
    .cycle_count(cycle_count)
  );

  // Second instance differs only in load base, to exercise address wrap.
  run_sequencer #(
    .ADDR_W(8), .LOAD_BASE(254), .LOAD_LEN(4), .RD_BASE(64), .RD_LEN(16),
    .START_CYC(2), .TIMEOUT(20)
  ) dut_b (
    .clk(clk), .reset(reset), .go(go),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready_b),
    .dut_start(dut_start_b), .dut_done(dut_done),
    .mem_wen(mem_wen_b), .mem_addr(mem_addr_b), .mem_din(mem_din_b), .mem_dout(mem_dout_b),
    .rb_valid(rb_valid_b), .rb_data(rb_data_b), .rb_ready(rb_ready),
    .busy(busy_b), .finished(finished_b), .timeout_err(timeout_err_b),
    .cycle_count(cycle_count_b)
  );

  // Data memory: synchronous write, combinational read.
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_din;
  end
  assign mem_dout = mem[mem_addr];

  // Count finished pulses between edges.
  always @(negedge clk) begin
    if (finished) fin_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic       go;
    logic       ldv;
    logic [7:0] ldd;
    logic       busy;
    logic       ds;
    logic       ldr;
    logic       wen;
    logic [7:0] addr;
    logic [7:0] addr_b;
    logic [7:0] din;
  } vec_t;

  vec_t tbl [8];

  task automatic apply_table();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      go = tbl[i].go; ld_valid = tbl[i].ldv; ld_data = tbl[i].ldd;
      dut_done = 1'b0; rb_ready = 1'b0;
      #1;
      chk("tbl_busy",   32'(busy),       32'(tbl[i].busy));
      chk("tbl_start",  32'(dut_start),  32'(tbl[i].ds));
      chk("tbl_ldrdy",  32'(ld_ready),   32'(tbl[i].ldr));
      chk("tbl_wen",    32'(mem_wen),    32'(tbl[i].wen));
      chk("tbl_addr",   32'(mem_addr),   32'(tbl[i].addr));
      chk("tbl_din",    32'(mem_din),    32'(tbl[i].din));
      chk("tbl_wen_b",  32'(mem_wen_b),  32'(tbl[i].wen));
      chk("tbl_addr_b", 32'(mem_addr_b), 32'(tbl[i].addr_b));
    end
  endtask

  initial begin
    int j;
    //           go ldv ldd     busy ds ldr wen addr addr_b din
    tbl[0] = '{1'b1, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0,   8'd0};
    tbl[1] = '{1'b0, 1'b1, 8'd11, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 8'd254, 8'd11};
    tbl[2] = '{1'b0, 1'b1, 8'd22, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 8'd255, 8'd22};
    tbl[3] = '{1'b0, 1'b1, 8'd33, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2, 8'd0,   8'd33};
    tbl[4] = '{1'b0, 1'b1, 8'd44, 1'b1, 1'b1, 1'b1, 1'b1, 8'd3, 8'd1,   8'd44};
    tbl[5] = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0,   8'd0};
    tbl[6] = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0,   8'd0};
    tbl[7] = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0,   8'd0};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) mem[64 + i] = 8'hA0 + 8'(i);

    reset = 1'b1; go = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
    dut_done = 1'b0; rb_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_start",   32'(dut_start),   1);
    chk("rst_busy",    32'(busy),        0);
    chk("rst_fin",     32'(finished),    0);
    chk("rst_tmo",     32'(timeout_err), 0);
    chk("rst_cycles",  32'(cycle_count), 0);
    chk("rst_ldrdy",   32'(ld_ready),    0);
    chk("rst_rbvalid", 32'(rb_valid),    0);
    chk("rst_wen",     32'(mem_wen),     0);
    chk("rst_addr",    32'(mem_addr),    0);
    chk("rst_din",     32'(mem_din),     0);
    reset = 1'b0;

    // Run 1: load, start hold, done on RUN cycle 10, readback with stalls.
    apply_table();
    for (int i = 0; i < 4; i++) chk("load_mem", 32'(mem[i]), 32'(11 * (i + 1)));
    for (int m = 2; m <= 10; m++) begin
      @(negedge clk);
      dut_done = (m == 10);
      #1;
      chk("run_start", 32'(dut_start), 0);
      chk("run_wen",   32'(mem_wen),   0);
      chk("run_addr",  32'(mem_addr),  0);
      chk("run_count", 32'(cycle_count), 32'(m - 1));
    end
    j = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      dut_done = 1'b0;
      rb_ready = (c == 1 || c == 2) ? 1'b0 : 1'b1;
      #1;
      if (c == 0) chk("done_count", 32'(cycle_count), 10);
      chk("rd_valid", 32'(rb_valid),  1);
      chk("rd_start", 32'(dut_start), 1);
      chk("rd_addr",  32'(mem_addr),  32'(64 + j));
      chk("rd_data",  32'(rb_data),   32'(8'hA0 + 8'(j)));
      if (rb_ready) j++;
    end
    @(negedge clk);
    rb_ready = 1'b0;
    #1;
    chk("fin1_pulse", 32'(finished), 1);
    chk("fin1_rbv",   32'(rb_valid), 0);
    chk("fin1_tmo",   32'(timeout_err), 0);
    @(negedge clk);
    #1;
    chk("idle1_fin",   32'(finished),    0);
    chk("idle1_busy",  32'(busy),        0);
    chk("idle1_count", 32'(cycle_count), 10);

    // Run 2: done never arrives; go during the run must be ignored.
    apply_table();
    for (int m = 2; m <= 20; m++) begin
      @(negedge clk);
      go = (m == 5 || m == 6);
      #1;
      chk("tmo_start", 32'(dut_start),   0);
      chk("tmo_busy",  32'(busy),        1);
      chk("tmo_count", 32'(cycle_count), 32'(m - 1));
    end
    @(negedge clk);
    go = 1'b0;
    #1;
    chk("tmo_fin",   32'(finished),    1);
    chk("tmo_err",   32'(timeout_err), 1);
    chk("tmo_rbv",   32'(rb_valid),    0);
    chk("tmo_final", 32'(cycle_count), 20);
    @(negedge clk);
    #1;
    chk("tmo_idle_busy", 32'(busy),        0);
    chk("tmo_sticky",    32'(timeout_err), 1);

    // Run 3: new go clears status; reset mid-load after two bytes.
    @(negedge clk);
    go = 1'b1;
    #1;
    chk("go_tmo_held", 32'(timeout_err), 1);
    @(negedge clk);
    go = 1'b0; ld_valid = 1'b1; ld_data = 8'h99;
    #1;
    chk("go_tmo_clr",   32'(timeout_err), 0);
    chk("go_count_clr", 32'(cycle_count), 0);
    chk("ld3_addr0",    32'(mem_addr),    0);
    @(negedge clk);
    #1;
    chk("ld3_addr1", 32'(mem_addr), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstcyc_wen", 32'(mem_wen), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy",  32'(busy),      0);
    chk("abort_start", 32'(dut_start), 1);
    chk("abort_wen",   32'(mem_wen),   0);
    chk("abort_ldrdy", 32'(ld_ready),  0);
    chk("abort_mem0",  32'(mem[0]),    32'h99);
    chk("abort_mem1",  32'(mem[1]),    32'h99);
    chk("abort_mem2",  32'(mem[2]),    33);
    chk("abort_mem3",  32'(mem[3]),    44);
    ld_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("fin_pulses", 32'(fin_cnt), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
